// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment/extension, writeback select and retire counter.
// One cycle latency: MEM inputs captured at posedge N drive the register file during cycle N+1; Stall holds, Flush bubbles.
module mem_wb_stage #(
    parameter int COUNT_WIDTH         = 32,
    parameter bit ZERO_WRITE_SUPPRESS = 1'b1
) (
    input  logic                   Clk,
    input  logic                   Clr,
    input  logic                   Stall,
    input  logic                   Flush,
    input  logic                   M_Valid,
    input  logic                   M_Reg_Write,
    input  logic                   M_Mem_To_Reg,
    input  logic                   M_Link,
    input  logic [2:0]             M_Load_Type,
    input  logic [4:0]             M_Write_Reg_Addr,
    input  logic [31:0]            M_Alu_Result,
    input  logic [31:0]            M_Mem_Read_Data,
    input  logic [31:0]            M_PC_Plus8,
    output logic                   W_Valid,
    output logic                   Reg_Write,
    output logic [4:0]             Write_Reg_Addr,
    output logic [31:0]            Write_Reg_Data,
    output logic [COUNT_WIDTH-1:0] Retire_Count
);

    logic        w_valid;
    logic        w_reg_write;
    logic        w_mem_to_reg;
    logic        w_link;
    logic [2:0]  w_load_type;
    logic [4:0]  w_addr;
    logic [31:0] w_alu;
    logic [31:0] w_mem_data;
    logic [31:0] w_pc8;

    logic [COUNT_WIDTH-1:0] retire_count;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            w_valid      <= 1'b0;
            w_reg_write  <= 1'b0;
            w_mem_to_reg <= 1'b0;
            w_link       <= 1'b0;
            w_load_type  <= 3'd0;
            w_addr       <= 5'd0;
            w_alu        <= 32'd0;
            w_mem_data   <= 32'd0;
            w_pc8        <= 32'd0;
        end else if (Flush) begin
            w_valid      <= 1'b0;
            w_reg_write  <= 1'b0;
            w_mem_to_reg <= 1'b0;
            w_link       <= 1'b0;
            w_load_type  <= 3'd0;
            w_addr       <= 5'd0;
            w_alu        <= 32'd0;
            w_mem_data   <= 32'd0;
            w_pc8        <= 32'd0;
        end else if (!Stall) begin
            w_valid      <= M_Valid;
            w_reg_write  <= M_Reg_Write;
            w_mem_to_reg <= M_Mem_To_Reg;
            w_link       <= M_Link;
            w_load_type  <= M_Load_Type;
            w_addr       <= M_Write_Reg_Addr;
            w_alu        <= M_Alu_Result;
            w_mem_data   <= M_Mem_Read_Data;
            w_pc8        <= M_PC_Plus8;
        end
    end

    // An instruction retires when it leaves WB, so a stalled one is counted only once.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            retire_count <= '0;
        end else if (w_valid && !Stall) begin
            retire_count <= retire_count + 1'b1;
        end
    end

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;
    logic [31:0] wb_data;
    logic        addr_ok;
    logic        reg_write;

    always_comb begin
        lane_byte = 8'h00;
        case (w_alu[1:0])
            2'd0:    lane_byte = w_mem_data[7:0];
            2'd1:    lane_byte = w_mem_data[15:8];
            2'd2:    lane_byte = w_mem_data[23:16];
            default: lane_byte = w_mem_data[31:24];
        endcase
        lane_half = w_alu[1] ? w_mem_data[31:16] : w_mem_data[15:0];

        load_data = w_mem_data;
        case (w_load_type)
            3'b001:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b010:  load_data = {24'd0, lane_byte};
            3'b011:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_data = {16'd0, lane_half};
            default: load_data = w_mem_data;
        endcase

        wb_data = w_alu;
        if (w_link) begin
            wb_data = w_pc8;
        end else if (w_mem_to_reg) begin
            wb_data = load_data;
        end
    end

    assign addr_ok   = ZERO_WRITE_SUPPRESS ? (w_addr != 5'd0) : 1'b1;
    assign reg_write = w_valid & w_reg_write & addr_ok;

    assign W_Valid        = w_valid;
    assign Reg_Write      = reg_write;
    assign Write_Reg_Addr = reg_write ? w_addr : 5'd0;
    assign Write_Reg_Data = reg_write ? wb_data : 32'd0;
    assign Retire_Count   = retire_count;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized plus directed bench for mem_wb_stage against a behavioural writeback model.
module tb_mem_wb_stage;

    logic        Clk;
    logic        Clr;
    logic        Stall;
    logic        Flush;
    logic        M_Valid;
    logic        M_Reg_Write;
    logic        M_Mem_To_Reg;
    logic        M_Link;
    logic [2:0]  M_Load_Type;
    logic [4:0]  M_Write_Reg_Addr;
    logic [31:0] M_Alu_Result;
    logic [31:0] M_Mem_Read_Data;
    logic [31:0] M_PC_Plus8;

    logic        W_Valid;
    logic        Reg_Write;
    logic [4:0]  Write_Reg_Addr;
    logic [31:0] Write_Reg_Data;
    logic [31:0] Retire_Count;

    logic        w4_valid;
    logic        w4_reg_write;
    logic [4:0]  w4_addr;
    logic [31:0] w4_data;
    logic [3:0]  w4_count;

    mem_wb_stage dut (
        .Clk(Clk), .Clr(Clr), .Stall(Stall), .Flush(Flush),
        .M_Valid(M_Valid), .M_Reg_Write(M_Reg_Write), .M_Mem_To_Reg(M_Mem_To_Reg),
        .M_Link(M_Link), .M_Load_Type(M_Load_Type), .M_Write_Reg_Addr(M_Write_Reg_Addr),
        .M_Alu_Result(M_Alu_Result), .M_Mem_Read_Data(M_Mem_Read_Data), .M_PC_Plus8(M_PC_Plus8),
        .W_Valid(W_Valid), .Reg_Write(Reg_Write), .Write_Reg_Addr(Write_Reg_Addr),
        .Write_Reg_Data(Write_Reg_Data), .Retire_Count(Retire_Count)
    );

    mem_wb_stage #(.COUNT_WIDTH(4)) dut4 (
        .Clk(Clk), .Clr(Clr), .Stall(Stall), .Flush(Flush),
        .M_Valid(M_Valid), .M_Reg_Write(M_Reg_Write), .M_Mem_To_Reg(M_Mem_To_Reg),
        .M_Link(M_Link), .M_Load_Type(M_Load_Type), .M_Write_Reg_Addr(M_Write_Reg_Addr),
        .M_Alu_Result(M_Alu_Result), .M_Mem_Read_Data(M_Mem_Read_Data), .M_PC_Plus8(M_PC_Plus8),
        .W_Valid(w4_valid), .Reg_Write(w4_reg_write), .Write_Reg_Addr(w4_addr),
        .Write_Reg_Data(w4_data), .Retire_Count(w4_count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        m2r;
        logic        link;
        logic [2:0]  lt;
        logic [4:0]  addr;
        logic [31:0] alu;
        logic [31:0] raw;
        logic [31:0] pc8;
    } instr_t;

    instr_t wb_slot;
    int     retired;
    int     n_vec = 0;
    int     n_err = 0;

    // Instruction currently in WB and the number that have left WB since reset.
    always @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            wb_slot <= '0;
            retired <= 0;
        end else begin
            if (wb_slot.valid && !Stall) retired <= retired + 1;
            if (Flush) wb_slot <= '0;
            else if (!Stall)
                wb_slot <= '{M_Valid, M_Reg_Write, M_Mem_To_Reg, M_Link, M_Load_Type,
                             M_Write_Reg_Addr, M_Alu_Result, M_Mem_Read_Data, M_PC_Plus8};
        end
    end

    function automatic logic writes(instr_t s);
        return s.valid && s.rw && (s.addr != 5'd0);
    endfunction

    function automatic logic [31:0] wb_value(instr_t s);
        logic [31:0] sh;
        if (!writes(s)) return 32'd0;
        if (s.link) return s.pc8;
        if (!s.m2r) return s.alu;
        case (s.lt)
            3'd1: begin sh = s.raw >> (8 * s.alu[1:0]); return {{24{sh[7]}}, sh[7:0]}; end
            3'd2: begin sh = s.raw >> (8 * s.alu[1:0]); return {24'd0, sh[7:0]}; end
            3'd3: begin sh = s.raw >> (16 * s.alu[1]); return {{16{sh[15]}}, sh[15:0]}; end
            3'd4: begin sh = s.raw >> (16 * s.alu[1]); return {16'd0, sh[15:0]}; end
            default: return s.raw;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        chk("w_valid", {31'd0, W_Valid}, {31'd0, wb_slot.valid});
        chk("reg_write", {31'd0, Reg_Write}, {31'd0, writes(wb_slot)});
        chk("wr_addr", {27'd0, Write_Reg_Addr}, writes(wb_slot) ? {27'd0, wb_slot.addr} : 32'd0);
        chk("wr_data", Write_Reg_Data, wb_value(wb_slot));
        chk("count", Retire_Count, retired);
        chk("count4", {28'd0, w4_count}, retired % 16);
    end

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic lnk,
                         input logic [2:0] lt, input logic [4:0] a, input logic [31:0] alu,
                         input logic [31:0] raw, input logic [31:0] pc8);
        M_Valid = v; M_Reg_Write = rw; M_Mem_To_Reg = m2r; M_Link = lnk; M_Load_Type = lt;
        M_Write_Reg_Addr = a; M_Alu_Result = alu; M_Mem_Read_Data = raw; M_PC_Plus8 = pc8;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_clr();
        #2 Clr = 1'b1;
        #1 Clr = 1'b0;
    endtask

    logic [2:0]  ld_type [6] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd0};
    logic [31:0] ld_addr [6] = '{32'h1003, 32'h2002, 32'h3001, 32'h4002, 32'h5000, 32'h6003};
    logic [31:0] ld_exp  [6] = '{32'hFFFFFF80, 32'h000000FF, 32'h0000007F,
                                 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
    int c0;

    initial begin
        Clr = 1'b1; Stall = 1'b0; Flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_valid", {31'd0, W_Valid}, 32'd0);
        chk("rst_data", Write_Reg_Data, 32'd0);
        chk("rst_count", Retire_Count, 32'd0);
        #4 Clr = 1'b0;

        drive(1, 1, 0, 0, 0, 5, 32'h12345678, 32'h0, 32'h0);
        tick();
        chk("alu_we", {31'd0, Reg_Write}, 32'd1);
        chk("alu_addr", {27'd0, Write_Reg_Addr}, 32'd5);
        chk("alu_data", Write_Reg_Data, 32'h12345678);
        chk("alu_cnt0", Retire_Count, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("alu_cnt1", Retire_Count, 32'd1);

        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 1, 0, ld_type[i], 5'd9, ld_addr[i], 32'h80FF7F01, 32'h0);
            tick();
            chk($sformatf("load%0d", i), Write_Reg_Data, ld_exp[i]);
        end

        drive(1, 1, 0, 0, 0, 0, 32'hDEAD0000, 32'h0, 32'h0);
        tick();
        chk("zero_we", {31'd0, Reg_Write}, 32'd0);
        chk("zero_data", Write_Reg_Data, 32'd0);
        for (int m = 0; m < 2; m++) begin
            drive(1, 1, m[0], 1, 3'd1, 31, 32'h11112222, 32'h33334444, 32'h00400010);
            tick();
            chk("link_data", Write_Reg_Data, 32'h00400010);
            chk("link_addr", {27'd0, Write_Reg_Addr}, 32'd31);
        end

        drive(1, 1, 0, 0, 0, 7, 32'hA5A5A5A5, 32'h0, 32'h0);
        tick();
        c0 = retired;
        Stall = 1'b1;
        drive(1, 1, 0, 0, 0, 8, 32'h0BAD0BAD, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_data", Write_Reg_Data, 32'hA5A5A5A5);
            chk("stall_cnt", Retire_Count, c0);
        end
        Stall = 1'b0;
        tick();
        chk("unstall_cnt", Retire_Count, c0 + 1);
        chk("unstall_data", Write_Reg_Data, 32'h0BAD0BAD);
        c0 = retired;
        Stall = 1'b1; Flush = 1'b1;
        tick();
        chk("fs_valid", {31'd0, W_Valid}, 32'd0);
        chk("fs_cnt", Retire_Count, c0);
        Stall = 1'b0; Flush = 1'b0;
        drive(1, 1, 0, 0, 0, 7, 32'hA5A5A5A5, 32'h0, 32'h0);
        tick();
        c0 = retired;
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("fl_valid", {31'd0, W_Valid}, 32'd0);
        chk("fl_cnt", Retire_Count, c0 + 1);

        pulse_clr();
        drive(1, 1, 0, 0, 0, 3, 32'h00000077, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) tick();
        chk("pre_clr_cnt", Retire_Count, 32'd7);
        chk("pre_clr_valid", {31'd0, W_Valid}, 32'd1);
        #2 Clr = 1'b1;
        #1;
        chk("aclr_valid", {31'd0, W_Valid}, 32'd0);
        chk("aclr_we", {31'd0, Reg_Write}, 32'd0);
        chk("aclr_data", Write_Reg_Data, 32'd0);
        chk("aclr_cnt", Retire_Count, 32'd0);
        #1 Clr = 1'b0;

        for (int i = 0; i < 18; i++) tick();
        chk("wrap_cnt4", {28'd0, w4_count}, 32'd1);
        chk("wrap_cnt32", Retire_Count, 32'd17);

        for (int i = 0; i < 600; i++) begin
            Stall = ($urandom_range(0, 3) == 0);
            Flush = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  $urandom, $urandom, $urandom);
            if ($urandom_range(0, 99) == 0) pulse_clr();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
